// File: rtl/quadrant_request_queue.sv
// quadrant_request_queue
// Turns the PS/2 driver's 16 quadrant confirm pulses into a 4-bit index.
// Drops the duplicate pulse that a make/break keypress produces, then queues
// accepted selections for the game side.
//
// Ports:
//   clk, rst        system clock; asynchronous active-high reset
//   quad_confirm    bit i = single-cycle confirm pulse for quadrant i+1
//   req_valid       head entry available
//   req_quadrant    head entry index (0..15 = quadrant 1..16)
//   req_ready       consumer accepts the head this cycle
//   fifo_count      number of queued entries
//   collision       one-cycle pulse: more than one confirm bit in a sample
//   overflow        sticky: an accepted event was dropped on a full queue
//   err_clear       synchronous clear of overflow (a same-cycle set wins)
module quadrant_request_queue #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DEDUP_CYCLES = 10_000_000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [15:0]                       quad_confirm,
  output logic                              req_valid,
  output logic [3:0]                        req_quadrant,
  input  logic                              req_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              collision,
  output logic                              overflow,
  input  logic                              err_clear
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMR_RQ = $clog2(DEDUP_CYCLES + 1);
  localparam int unsigned TMR_W  = (TMR_RQ > 24) ? TMR_RQ : 24;

  // Stage 0 registers
  logic             ev_valid_q, ev_valid_d;
  logic [IDX_W-1:0] ev_idx_q, ev_idx_d;
  logic             collision_q, collision_d;

  // Stage 1 (dedup) registers
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [TMR_W-1:0] dd_timer_q, dd_timer_d;

  // FIFO registers
  logic [IDX_W-1:0] mem_q [FIFO_DEPTH];
  logic [IDX_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;

  logic timer_live;
  logic accept;
  logic pop;
  logic push_ok;

  // Stage 0: priority-encode the lowest set bit, flag multi-bit samples
  always_comb begin
    ev_valid_d  = (quad_confirm != '0);
    ev_idx_d    = '0;
    for (int i = 15; i >= 0; i--) begin
      if (quad_confirm[i]) ev_idx_d = IDX_W'(i);
    end
    collision_d = ((quad_confirm & (quad_confirm - 16'd1)) != '0);
  end

  // Stage 1: suppress a repeat of the last accepted index inside the window
  always_comb begin
    timer_live = (dd_timer_q != '0);
    accept     = ev_valid_q && !((ev_idx_q == last_idx_q) && timer_live);
    last_idx_d = last_idx_q;
    dd_timer_d = dd_timer_q;
    if (accept) begin
      last_idx_d = ev_idx_q;
      dd_timer_d = TMR_W'(DEDUP_CYCLES);
    end else if (timer_live) begin
      dd_timer_d = dd_timer_q - TMR_W'(1);
    end
  end

  // FIFO: a pop frees a slot for a same-cycle push even when full
  always_comb begin
    pop      = (count_q != '0) && req_ready;
    push_ok  = accept && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = ev_idx_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Head is registered from the next-state view so a write into an empty
    // queue is visible in the cycle req_valid rises.
    head_d  = mem_d[rd_ptr_d];
    valid_d = (count_d != '0);
    if (accept && !push_ok)  overflow_d = 1'b1;
    else if (err_clear)      overflow_d = 1'b0;
    else                     overflow_d = overflow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid_q  <= 1'b0;
      ev_idx_q    <= '0;
      collision_q <= 1'b0;
      last_idx_q  <= '0;
      dd_timer_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      ev_valid_q  <= ev_valid_d;
      ev_idx_q    <= ev_idx_d;
      collision_q <= collision_d;
      last_idx_q  <= last_idx_d;
      dd_timer_q  <= dd_timer_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign req_valid    = valid_q;
  assign req_quadrant = head_q;
  assign fifo_count   = count_q;
  assign collision    = collision_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_quadrant_request_queue.sv
// Scoreboard bench for quadrant_request_queue: stimulus pushes expected
// indices, a negedge monitor pops and compares on every handshake.
module tb_quadrant_request_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DD    = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] quad_confirm;
  logic        req_valid;
  logic [3:0]  req_quadrant;
  logic        req_ready;
  logic [2:0]  fifo_count;
  logic        collision;
  logic        overflow;
  logic        err_clear;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  sb[$];

  quadrant_request_queue #(.FIFO_DEPTH(DEPTH), .DEDUP_CYCLES(DD)) dut (
    .clk(clk), .rst(rst), .quad_confirm(quad_confirm),
    .req_valid(req_valid), .req_quadrant(req_quadrant), .req_ready(req_ready),
    .fifo_count(fifo_count), .collision(collision), .overflow(overflow),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted head must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req: got quadrant %0d expected none", req_quadrant);
      end else begin
        chk("req_quadrant", 32'(req_quadrant), 32'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [15:0] v);
    quad_confirm = v;
    tick();
    quad_confirm = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    #2;
    chk("rst_valid", 32'(req_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    quad_confirm = '0;
    req_ready    = 1'b0;
    err_clear    = 1'b0;
    #2;
    chk("init_valid", 32'(req_valid), 0);
    chk("init_quadrant", 32'(req_quadrant), 0);
    chk("init_collision", 32'(collision), 0);
    chk("init_overflow", 32'(overflow), 0);
    tick();
    rst = 1'b0;
    tick();

    // Single pulse, 2-cycle latency, pops immediately
    req_ready = 1'b1;
    sb.push_back(4'd4);
    pulse(16'h0010);
    chk("t1_valid_n1", 32'(req_valid), 0);
    chk("t1_coll_n1", 32'(collision), 0);
    tick();
    chk("t1_valid_n2", 32'(req_valid), 1);
    chk("t1_quad_n2", 32'(req_quadrant), 4);
    tick();
    chk("t1_valid_n3", 32'(req_valid), 0);
    chk("t1_count_n3", 32'(fifo_count), 0);

    // Dedup window: 4 @0, 4 @100 dropped, 7 @101, 4 @1005
    do_reset();
    req_ready = 1'b1;
    sb.push_back(4'd4);
    pulse(16'h0010);
    idle(99);
    pulse(16'h0010);
    sb.push_back(4'd7);
    pulse(16'h0080);
    idle(903);
    sb.push_back(4'd4);
    pulse(16'h0010);
    idle(5);
    // Exact boundary: repeat at +DD suppressed, at +DD+1 accepted
    sb.push_back(4'd9);
    pulse(16'h0200);
    idle(int'(DD) - 1);
    pulse(16'h0200);
    sb.push_back(4'd9);
    pulse(16'h0200);
    idle(5);
    chk("t2_drained", 32'(sb.size()), 0);
    chk("t2_count", 32'(fifo_count), 0);

    // Collision: bits 2 and 9 -> index 2, one-cycle flag
    sb.push_back(4'd2);
    pulse(16'h0204);
    chk("t3_coll_n1", 32'(collision), 1);
    tick();
    chk("t3_coll_n2", 32'(collision), 0);
    idle(3);
    chk("t3_drained", 32'(sb.size()), 0);

    // Overflow: six events into a depth-4 queue with no consumer
    do_reset();
    req_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i != 4) pulse(16'(1 << i));
      if (i < 4) sb.push_back(4'(i));
    end
    idle(2);
    chk("t4_count_full", 32'(fifo_count), 4);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_head", 32'(req_quadrant), 0);
    req_ready = 1'b1;
    idle(4);
    req_ready = 1'b0;
    chk("t4_count_empty", 32'(fifo_count), 0);
    chk("t4_overflow_sticky", 32'(overflow), 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t4_overflow_clr", 32'(overflow), 0);
    // Fill again, then overflow in the same cycle as err_clear: set wins
    for (int i = 0; i < 4; i++) begin
      pulse(16'(1 << (i + 10)));
      sb.push_back(4'(i + 10));
    end
    idle(2);
    pulse(16'h0001);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t4_set_wins", 32'(overflow), 1);
    req_ready = 1'b1;
    idle(5);
    chk("t4_drained2", 32'(sb.size()), 0);

    // Full queue with push and pop in the same cycle
    do_reset();
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse(16'(1 << i));
      sb.push_back(4'(i));
    end
    idle(2);
    chk("t5_full", 32'(fifo_count), 4);
    sb.push_back(4'd10);
    pulse(16'h0400);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("t5_count_same", 32'(fifo_count), 4);
    chk("t5_no_overflow", 32'(overflow), 0);
    chk("t5_head", 32'(req_quadrant), 1);
    req_ready = 1'b1;
    idle(5);
    chk("t5_drained", 32'(sb.size()), 0);

    // Asynchronous reset mid-cycle with 3 entries queued
    do_reset();
    req_ready = 1'b0;
    for (int i = 1; i < 4; i++) pulse(16'(1 << i));
    idle(2);
    chk("t6_count3", 32'(fifo_count), 3);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("t6_async_valid", 32'(req_valid), 0);
    chk("t6_async_count", 32'(fifo_count), 0);
    chk("t6_async_quad", 32'(req_quadrant), 0);
    #3;
    rst = 1'b0;
    tick();
    req_ready = 1'b1;
    sb.push_back(4'd0);
    pulse(16'h0001);
    tick();
    chk("t6_valid_after", 32'(req_valid), 1);
    chk("t6_quad_after", 32'(req_quadrant), 0);
    idle(3);
    chk("final_sb_empty", 32'(sb.size()), 0);
    chk("final_count", 32'(fifo_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
